cordic_phase_nco: RTL and testbench
===================================

Name: cordic_phase_nco

Overview:
- Phase-generation stage directly upstream of the 16-stage CORDIC rotator.
- Runs a modulo-2^PHASE_W phase accumulator (full turn = 2^PHASE_W) and folds each phase into the rotator's convergence range [-pi/2, pi/2].
- Converts the folded phase to a signed Q16.16 radian angle that drives the rotator's theta input.
- Carries a quadrant-flip flag, and its valid, through a delay line matched to the rotator latency so the downstream sign-correction stage can negate cos/sin in step.

Parameters:
- PHASE_W, 32: accumulator width; 2^PHASE_W equals 2*pi. Legal range 18..32.
- CORDIC_LAT, 32: rotator latency in cycles; sets the depth of the flip/valid delay line. Must be >= 1.
- TWO_PI_Q16, 411775: 2*pi in Q16.16 (0x6487F), used as the conversion multiplier.

Ports:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_reset, input, 1: asynchronous, active-high reset.
- i_ce, input, 1: sample enable; emit the current phase, then advance.
- i_freq, input, PHASE_W: unsigned phase increment per enabled sample.
- i_load, input, 1: synchronous phase load.
- i_phase, input, PHASE_W: value loaded on i_load.
- o_theta, output, 32 signed: Q16.16 radians in [-pi/2, pi/2]; connects to the rotator's theta input.
- o_valid, output, 1: o_theta holds a new sample.
- o_flip, output, 1: quadrant flag aligned with o_theta.
- o_flip_dly, output, 1: o_flip delayed CORDIC_LAT cycles.
- o_valid_dly, output, 1: o_valid delayed CORDIC_LAT cycles.

Behaviour:
- Reset (asynchronous, any cycle, including mid-stream):
  - acc = 0.
  - All pipeline registers, o_theta, o_valid, o_flip, and the entire delay line clear to 0 immediately.
  - The first o_valid after reset release reflects the first i_ce after release.
- Accumulator:
  - i_load has priority over i_ce.
  - i_load and i_ce together: stage 1 captures i_phase; acc <= i_phase + i_freq.
  - i_load alone: acc <= i_phase; no sample is issued.
  - i_ce alone: stage 1 captures acc; acc <= acc + i_freq, modulo 2^PHASE_W. Wrap is silent.
  - Neither: acc holds.
- Pipeline: free-running, no stall, three register stages.
  - S1: p1, v1 <= i_ce.
  - S2 (fold): q = p1[PHASE_W-1:PHASE_W-2].
    - q = 01 or 10: p2 = p1 - 2^(PHASE_W-1) (subtract pi), flip2 = 1.
    - q = 00 or 11: p2 = p1, flip2 = 0.
    - p2 is interpreted as signed, range [-2^(PHASE_W-2), 2^(PHASE_W-2)).
  - S3 (convert): t = p2[PHASE_W-1:PHASE_W-16], signed 16-bit turns Q0.16.
    - o_theta = (t * TWO_PI_Q16) >>> 16, with a 48-bit signed intermediate and arithmetic shift (floor). No rounding.
    - o_flip <= flip2; o_valid <= v2.
- Latency: i_ce high at edge k gives o_valid, o_theta and o_flip updated at edge k+2, i.e. 3 cycles from sample request.
- Output range:
  - t = -16384 gives o_theta = -102944.
  - t = +16383 gives o_theta = +102937.
  - Both lie inside the rotator's convergence range (about +/-1.74 rad).
- Sign correction contract (downstream): when the flag is set, cos_out = -cos and sin_out = -sin. This holds for both quadrants 01 and 10, since rotating by pi negates both.
- Delay line:
  - CORDIC_LAT-deep shift register of {valid, flip}; shifts every cycle.
  - o_flip_dly and o_valid_dly equal o_flip and o_valid from exactly CORDIC_LAT cycles earlier.
- When o_valid = 0, o_theta and o_flip hold their last values.
- Boundary handling:
  - i_freq = 0 gives a constant phase.
  - i_freq = 2^(PHASE_W-1) alternates the flip flag with identical o_theta.
  - Accumulator wrap past 2^PHASE_W - 1 produces no discontinuity beyond the modulo.

Test Plan:
- Reset, then i_freq = 0x40000000, i_ce held high from cycle 0. Outputs from cycle 3:
  - {theta, flip} = {0, 0}, {-102944, 1}, {0, 1}, {-102944, 0}, then repeats.
  - o_valid stays 1.
- i_phase = 0x20000000 with i_load=1, i_ce=0 for one cycle, then i_ce pulse, freq 0:
  - o_theta = 51471 (pi/4), o_flip = 0.
  - o_valid high for exactly one cycle, 3 cycles after the pulse.
- i_phase = 0xE0000000, single i_ce: o_theta = -51472, o_flip = 0.
- i_phase = 0x60000000 (3pi/4), single i_ce: o_theta = -51472, o_flip = 1.
- i_freq = 0x10000000, 20 consecutive i_ce:
  - acc wraps after 16 samples.
  - Samples 16..19 repeat samples 0..3 exactly.
- CORDIC_LAT = 32, toggling i_ce, with i_reset asserted for one cycle mid-stream:
  - o_flip_dly/o_valid_dly match o_flip/o_valid shifted 32 cycles.
  - All outputs read 0 in the same cycle reset asserts.
  - No stale valids emerge afterwards.

Source files
------------

// File: rtl/cordic_phase_nco.sv
// Phase accumulator and quadrant folder feeding the 16-stage CORDIC rotator.
// Produces a Q16.16 radian angle in [-pi/2, pi/2] plus a quadrant-flip flag.
// The flag and the sample valid are also delivered through a delay line that
// is matched to the rotator latency.
module cordic_phase_nco #(
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned CORDIC_LAT = 32,
  parameter int unsigned TWO_PI_Q16 = 411775
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_ce,
  input  logic [PHASE_W-1:0]        i_freq,
  input  logic                      i_load,
  input  logic [PHASE_W-1:0]        i_phase,
  output logic signed [31:0]        o_theta,
  output logic                      o_valid,
  output logic                      o_flip,
  output logic                      o_flip_dly,
  output logic                      o_valid_dly
);

  localparam logic [15:0]        HALF_TURN  = 16'h8000;
  localparam logic signed [47:0] TWO_PI_48  = 48'(TWO_PI_Q16);

  logic [PHASE_W-1:0] acc;

  // Only the top 16 phase bits reach the angle conversion, so the pipeline
  // carries just those; subtracting pi only touches the MSB, so the fold is
  // exact on the truncated value.
  logic [15:0]        p1;
  logic               v1;
  logic [15:0]        p2;
  logic               flip2;
  logic               v2;

  logic [1:0]         fold_q;
  logic               fold_flip;
  logic [15:0]        fold_p;
  logic signed [47:0] t_ext;
  logic signed [47:0] prod;
  logic signed [31:0] theta_next;

  logic [1:0]         dly [CORDIC_LAT];

  // Accumulator update and stage-1 phase capture; load beats sample enable.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc <= '0;
      p1  <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= i_ce;
      if (i_load) begin
        if (i_ce) begin
          p1  <= i_phase[PHASE_W-1:PHASE_W-16];
          acc <= i_phase + i_freq;
        end else begin
          acc <= i_phase;
        end
      end else if (i_ce) begin
        p1  <= acc[PHASE_W-1:PHASE_W-16];
        acc <= acc + i_freq;
      end
    end
  end

  // Fold quadrants 01/10 onto the right half-plane by subtracting pi.
  always_comb begin
    fold_q    = p1[15:14];
    fold_flip = fold_q[1] ^ fold_q[0];
    fold_p    = fold_flip ? (p1 - HALF_TURN) : p1;
  end

  // Stage 2: register the folded phase and its flip flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      p2    <= '0;
      flip2 <= 1'b0;
      v2    <= 1'b0;
    end else begin
      p2    <= fold_p;
      flip2 <= fold_flip;
      v2    <= v1;
    end
  end

  // Turns (signed Q0.16) times 2*pi (Q16.16), floored back to Q16.16.
  always_comb begin
    t_ext      = {{32{p2[15]}}, p2};
    prod       = t_ext * TWO_PI_48;
    theta_next = prod[47:16];
  end

  // Stage 3: outputs update only on a valid sample, otherwise hold.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_theta <= '0;
      o_flip  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= v2;
      if (v2) begin
        o_theta <= theta_next;
        o_flip  <= flip2;
      end
    end
  end

  // Delay line of {valid, flip} matched to the rotator latency.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < CORDIC_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {o_valid, o_flip};
      for (int unsigned i = 1; i < CORDIC_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign o_valid_dly = dly[CORDIC_LAT-1][1];
  assign o_flip_dly  = dly[CORDIC_LAT-1][0];

endmodule

// File: tb/tb_cordic_phase_nco.sv
// Directed bench for cordic_phase_nco: reset, quadrant stream, load/fold
// vectors, accumulator wrap and the matched delay line across a reset.
module tb_cordic_phase_nco;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_ce;
  logic [31:0]        i_freq;
  logic               i_load;
  logic [31:0]        i_phase;
  logic signed [31:0] o_theta;
  logic               o_valid;
  logic               o_flip;
  logic               o_flip_dly;
  logic               o_valid_dly;

  int errors = 0;
  int checks = 0;

  cordic_phase_nco #(
    .PHASE_W   (32),
    .CORDIC_LAT(32),
    .TWO_PI_Q16(411775)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ce       (i_ce),
    .i_freq     (i_freq),
    .i_load     (i_load),
    .i_phase    (i_phase),
    .o_theta    (o_theta),
    .o_valid    (o_valid),
    .o_flip     (o_flip),
    .o_flip_dly (o_flip_dly),
    .o_valid_dly(o_valid_dly)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_ce = 1'b0; i_load = 1'b0; i_freq = '0; i_phase = '0;
    tick();
    tick();
    checks++;
    if ({o_theta, o_valid, o_flip, o_valid_dly, o_flip_dly} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: theta=%0d v=%b f=%b vd=%b fd=%b required all 0",
               o_theta, o_valid, o_flip, o_valid_dly, o_flip_dly);
    end
    i_reset = 1'b0;
  endtask

  // Quarter-turn increment straight after reset (acc = 0).
  task automatic test_quadrant_stream();
    int exp_t [4] = '{0, -102944, 0, -102944};
    bit exp_f [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    i_freq = 32'h4000_0000;
    i_ce   = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n >= 3) begin
        checks++;
        if (o_theta !== exp_t[(n-3)%4] || o_flip !== exp_f[(n-3)%4]) begin
          errors++;
          $display("FAIL quad_stream[%0d]: theta=%0d flip=%b required theta=%0d flip=%b",
                   n-3, o_theta, o_flip, exp_t[(n-3)%4], exp_f[(n-3)%4]);
        end
        checks++;
        if (o_valid !== 1'b1) begin
          errors++;
          $display("FAIL quad_valid[%0d]: valid=%b required 1", n-3, o_valid);
        end
      end
    end
    i_ce = 1'b0;
    for (int n = 0; n < 4; n++) tick();
  endtask

  // Load a phase alone, then issue one sample with zero increment.
  task automatic test_load_sample(input logic [31:0] phase, input int exp_t,
                                  input bit exp_f, input string name);
    i_freq  = '0;
    i_phase = phase;
    i_load  = 1'b1;
    i_ce    = 1'b0;
    tick();
    i_load = 1'b0;
    i_ce   = 1'b1;
    tick();
    i_ce = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early0: valid=%b required 0", name, o_valid);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early1: valid=%b required 0", name, o_valid);
    end
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_theta !== exp_t || o_flip !== exp_f) begin
      errors++;
      $display("FAIL %s_out: valid=%b theta=%0d flip=%b required valid=1 theta=%0d flip=%b",
               name, o_valid, o_theta, o_flip, exp_t, exp_f);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_theta !== exp_t || o_flip !== exp_f) begin
      errors++;
      $display("FAIL %s_hold: valid=%b theta=%0d flip=%b required valid=0 theta=%0d flip=%b",
               name, o_valid, o_theta, o_flip, exp_t, exp_f);
    end
    tick();
  endtask

  // Sixteenth-turn increment for 20 samples; the accumulator wraps at 16.
  task automatic test_wrap();
    int exp_t [16] = '{0, 25735, 51471, 77207, -102944, -77208, -51472, -25736,
                       0, 25735, 51471, 77207, -102944, -77208, -51472, -25736};
    bit exp_f [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int th [20];
    bit fl [20];
    i_phase = '0;
    i_load  = 1'b1;
    i_ce    = 1'b0;
    tick();
    i_load = 1'b0;
    i_freq = 32'h1000_0000;
    i_ce   = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      tick();
      if (n >= 3) begin
        th[n-3] = o_theta;
        fl[n-3] = o_flip;
        checks++;
        if (o_valid !== 1'b1 || o_theta !== exp_t[(n-3)%16] || o_flip !== exp_f[(n-3)%16]) begin
          errors++;
          $display("FAIL wrap[%0d]: valid=%b theta=%0d flip=%b required valid=1 theta=%0d flip=%b",
                   n-3, o_valid, o_theta, o_flip, exp_t[(n-3)%16], exp_f[(n-3)%16]);
        end
      end
      if (n == 20) i_ce = 1'b0;
    end
    for (int k = 16; k < 20; k++) begin
      checks++;
      if (th[k] !== th[k-16] || fl[k] !== fl[k-16]) begin
        errors++;
        $display("FAIL wrap_repeat[%0d]: theta=%0d flip=%b required theta=%0d flip=%b",
                 k, th[k], fl[k], th[k-16], fl[k-16]);
      end
    end
    for (int n = 0; n < 4; n++) tick();
  endtask

  // Asynchronous reset pulse: outputs must clear before the next edge.
  task automatic reset_pulse(input string name);
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_theta, o_valid, o_flip, o_valid_dly, o_flip_dly} !== 36'd0) begin
      errors++;
      $display("FAIL %s: theta=%0d v=%b f=%b vd=%b fd=%b required all 0",
               name, o_theta, o_valid, o_flip, o_valid_dly, o_flip_dly);
    end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  // Alternate-cycle sampling at a quarter-turn step from acc = 0; expected
  // outputs and their 32-cycle delayed copies come from a per-edge model.
  task automatic run_delay_segment(input int nedges, input string name);
    bit ce_e [128];
    bit sf   [128];
    int st   [128];
    bit ev   [128];
    bit ef   [128];
    int et   [128];
    bit fseq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int tseq [4] = '{0, -102944, 0, -102944};
    int cnt = 0;
    bit exp_vd;
    bit exp_fd;
    for (int n = 0; n < 128; n++) begin
      ce_e[n] = (n % 2) == 1;
      sf[n] = 1'b0;
      st[n] = 0;
      if (ce_e[n]) begin
        sf[n] = fseq[cnt % 4];
        st[n] = tseq[cnt % 4];
        cnt++;
      end
    end
    ev[0] = 1'b0; ef[0] = 1'b0; et[0] = 0;
    for (int n = 1; n < 128; n++) begin
      ev[n] = (n >= 3) ? ce_e[n-2] : 1'b0;
      ef[n] = ev[n] ? sf[n-2] : ef[n-1];
      et[n] = ev[n] ? st[n-2] : et[n-1];
    end
    i_load = 1'b0;
    i_freq = 32'h4000_0000;
    i_ce   = ce_e[1];
    for (int n = 1; n <= nedges; n++) begin
      tick();
      checks++;
      if (o_valid !== ev[n] || o_flip !== ef[n] || o_theta !== et[n]) begin
        errors++;
        $display("FAIL %s_out[%0d]: v=%b f=%b theta=%0d required v=%b f=%b theta=%0d",
                 name, n, o_valid, o_flip, o_theta, ev[n], ef[n], et[n]);
      end
      exp_vd = (n >= 32) ? ev[n-32] : 1'b0;
      exp_fd = (n >= 32) ? ef[n-32] : 1'b0;
      checks++;
      if (o_valid_dly !== exp_vd || o_flip_dly !== exp_fd) begin
        errors++;
        $display("FAIL %s_dly[%0d]: vd=%b fd=%b required vd=%b fd=%b",
                 name, n, o_valid_dly, o_flip_dly, exp_vd, exp_fd);
      end
      i_ce = ce_e[n+1];
    end
  endtask

  task automatic test_delay_line();
    reset_pulse("dly_reset_a");
    run_delay_segment(45, "dly_seg_a");
    reset_pulse("dly_reset_mid");
    run_delay_segment(80, "dly_seg_b");
    i_ce = 1'b0;
  endtask

  initial begin
    test_reset();
    test_quadrant_stream();
    test_load_sample(32'h2000_0000,  51471, 1'b0, "load_pi4");
    test_load_sample(32'hE000_0000, -51472, 1'b0, "load_neg_pi4");
    test_load_sample(32'h6000_0000, -51472, 1'b1, "load_3pi4");
    test_wrap();
    test_delay_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
